// File: rtl/vision_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : vision_pkg
//  Description : Shared constants and types for the camera vision front end.
//                Holds the BT.601-style luma weights, the frame-tracking state
//                type and the default frame geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package vision_pkg;

  // Luma weights scaled by 2^LUMA_SHIFT; they sum to 256.
  localparam int LUMA_WR    = 77;
  localparam int LUMA_WG    = 150;
  localparam int LUMA_WB    = 29;
  localparam int LUMA_SHIFT = 8;

  // Default frame geometry and channel width.
  localparam int IMG_WIDTH_DEFAULT  = 640;
  localparam int IMG_HEIGHT_DEFAULT = 480;
  localparam int PIXEL_BITS_DEFAULT = 8;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    STREAM   = 1'b1
  } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_position_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : frame_position_tracker
//  Description : Tracks the (x,y) position of accepted beats in a frame.
//                Decides whether a beat is forwarded, tags it with sof/eol/eof
//                and raises a one-cycle sof_error on an out-of-place sof.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_position_tracker
  import vision_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEFAULT,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic accept,
  input  logic in_sof,
  output logic forward,
  output logic sof,
  output logic eol,
  output logic eof,
  output logic sof_error
);

  localparam int X_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int Y_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [X_W-1:0] C_X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] C_Y_LAST = Y_W'(IMG_HEIGHT - 1);

  frame_state_t   r_state;
  frame_state_t   w_state_next;
  logic [X_W-1:0] r_x;
  logic [X_W-1:0] w_x_next;
  logic [X_W-1:0] w_pos_x;
  logic [Y_W-1:0] r_y;
  logic [Y_W-1:0] w_y_next;
  logic [Y_W-1:0] w_pos_y;
  logic           w_sof_error_next;

  // State, position counters and the registered error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= WAIT_SOF;
      r_x       <= '0;
      r_y       <= '0;
      sof_error <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_x       <= w_x_next;
      r_y       <= w_y_next;
      sof_error <= w_sof_error_next;
    end
  end

  // Next position: wrap at end of line, return to WAIT_SOF after the last pixel.
  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    if (accept && forward) begin
      if (eof) begin
        w_state_next = WAIT_SOF;
        w_x_next     = '0;
        w_y_next     = '0;
      end else if (eol) begin
        w_state_next = STREAM;
        w_x_next     = '0;
        w_y_next     = w_pos_y + Y_W'(1);
      end else begin
        w_state_next = STREAM;
        w_x_next     = w_pos_x + X_W'(1);
        w_y_next     = w_pos_y;
      end
    end
  end

  // Position of the current beat (an sof always restarts at the origin) and its tags.
  always_comb begin
    w_pos_x          = in_sof ? '0 : r_x;
    w_pos_y          = in_sof ? '0 : r_y;
    forward          = (r_state == STREAM) || in_sof;
    sof              = (w_pos_x == '0) && (w_pos_y == '0);
    eol              = (w_pos_x == C_X_LAST);
    eof              = eol && (w_pos_y == C_Y_LAST);
    w_sof_error_next = accept && (r_state == STREAM) && in_sof &&
                       ((r_x != '0) || (r_y != '0));
  end

endmodule
`default_nettype wire

// File: rtl/rgb_to_gray_stream.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_to_gray_stream
//  Description : RGB888 to 8-bit luma converter with valid/ready streaming.
//                Stage 1 registers the weighted channel products, stage 2 the
//                rounded sum. Frame position flags travel with each pixel.
//  Revision    : 1.0  initial release
// ============================================================================
module rgb_to_gray_stream
  import vision_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEFAULT,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEFAULT,
  parameter int PIXEL_BITS = PIXEL_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIXEL_BITS-1:0] in_r,
  input  logic [PIXEL_BITS-1:0] in_g,
  input  logic [PIXEL_BITS-1:0] in_b,
  input  logic                  in_sof,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [PIXEL_BITS-1:0] out_pixel,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sof_error
);

  // Weights sum to 2^LUMA_SHIFT, so the rounded sum never exceeds this width.
  localparam int SUM_W = PIXEL_BITS + LUMA_SHIFT;
  localparam logic [SUM_W-1:0] C_WR    = SUM_W'(LUMA_WR);
  localparam logic [SUM_W-1:0] C_WG    = SUM_W'(LUMA_WG);
  localparam logic [SUM_W-1:0] C_WB    = SUM_W'(LUMA_WB);
  localparam logic [SUM_W-1:0] C_ROUND = SUM_W'(1 << (LUMA_SHIFT - 1));

  logic                  w_s2_adv;
  logic                  w_s1_adv;
  logic                  w_accept;
  logic                  w_forward;
  logic                  w_sof;
  logic                  w_eol;
  logic                  w_eof;
  logic [PIXEL_BITS-1:0] w_luma;

  logic                  r_s1_valid;
  logic                  r_s1_sof;
  logic                  r_s1_eol;
  logic                  r_s1_eof;
  logic [SUM_W-1:0]      r_s1_pr;
  logic [SUM_W-1:0]      r_s1_pg;
  logic [SUM_W-1:0]      r_s1_pb;
  logic                  r_s2_valid;

  // in_ready depends only on pipeline occupancy and out_ready; held low in reset.
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = reset && w_s1_adv;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_s2_valid;
  assign w_luma    = PIXEL_BITS'((r_s1_pr + r_s1_pg + r_s1_pb + C_ROUND) >> LUMA_SHIFT);

  frame_position_tracker #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .accept    (w_accept),
    .in_sof    (in_sof),
    .forward   (w_forward),
    .sof       (w_sof),
    .eol       (w_eol),
    .eof       (w_eof),
    .sof_error (sof_error)
  );

  // Stage 1: capture channel products and frame flags of forwarded beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_s1_eof   <= 1'b0;
      r_s1_pr    <= '0;
      r_s1_pg    <= '0;
      r_s1_pb    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept && w_forward;
      if (w_accept && w_forward) begin
        r_s1_sof <= w_sof;
        r_s1_eol <= w_eol;
        r_s1_eof <= w_eof;
        r_s1_pr  <= C_WR * SUM_W'(in_r);
        r_s1_pg  <= C_WG * SUM_W'(in_g);
        r_s1_pb  <= C_WB * SUM_W'(in_b);
      end
    end
  end

  // Stage 2: rounded luma and flags; holds steady while downstream stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      out_pixel  <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_pixel <= w_luma;
        out_sof   <= r_s1_sof;
        out_eol   <= r_s1_eol;
        out_eof   <= r_s1_eof;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_to_gray_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_to_gray_stream
//  Description : Self-checking bench for rgb_to_gray_stream using a reduced
//                16x8 frame, a table of colour vectors and a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rgb_to_gray_stream;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int PB = 8;

  typedef struct { int r; int g; int b; int exp_pix; } vec_t;
  typedef struct { int pix; bit sof; bit eol; bit eof; } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PB-1:0] in_r = '0, in_g = '0, in_b = '0;
  logic          in_sof = 1'b0, in_valid = 1'b0;
  logic          in_ready;
  logic [PB-1:0] out_pixel;
  logic          out_sof, out_eol, out_eof, out_valid;
  logic          out_ready = 1'b1;
  logic          sof_error;

  int   checks = 0, errors = 0;
  int   cur_exp = -1;
  int   ready_mode = 1;
  int   cyc = 0;
  exp_t q[$];
  exp_t e;
  bit   m_stream = 0;
  int   m_x = 0, m_y = 0, px = 0, py = 0;
  bit   emit = 0, err_pending = 0, stall_prev = 0;
  logic [PB-1:0] held_pix;
  logic [2:0]    held_flags;
  int   n_out = 0, n_eol = 0, n_eof = 0, n_err = 0, n_sof = 0;
  vec_t tbl[10];

  rgb_to_gray_stream #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIXEL_BITS (PB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .in_sof    (in_sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_pixel (out_pixel),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sof_error (sof_error)
  );

  always #5 clk = ~clk;

  // Cycle counter for throughput measurement.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int luma(input int r, input int g, input int b);
    return (77 * r + 150 * g + 29 * b + 128) >> 8;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Downstream ready generator: forced low, forced high or random.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor and reference model: output scoreboard, stall stability, sof_error timing.
  always @(negedge clk) begin
    if (reset) begin
      if (stall_prev) begin
        checks++;
        if (!out_valid || out_pixel !== held_pix || {out_sof, out_eol, out_eof} !== held_flags) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b pix=%0d flags=%b, expected valid=1 pix=%0d flags=%b",
                   out_valid, out_pixel, {out_sof, out_eol, out_eof}, held_pix, held_flags);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got pix=%0d sof=%0b, expected no output", out_pixel, out_sof);
        end else begin
          e = q.pop_front();
          if (int'(out_pixel) != e.pix || out_sof != e.sof || out_eol != e.eol || out_eof != e.eof) begin
            errors++;
            $display("FAIL out_beat %0d: got pix=%0d sof=%0b eol=%0b eof=%0b, expected pix=%0d sof=%0b eol=%0b eof=%0b",
                     n_out, out_pixel, out_sof, out_eol, out_eof, e.pix, e.sof, e.eol, e.eof);
          end
        end
        n_out++;
        if (out_eol) n_eol++;
        if (out_eof) n_eof++;
        if (out_sof) n_sof++;
      end
      stall_prev = out_valid && !out_ready;
      held_pix   = out_pixel;
      held_flags = {out_sof, out_eol, out_eof};
      if (sof_error || err_pending) begin
        checks++;
        if (sof_error !== err_pending) begin
          errors++;
          $display("FAIL sof_error_pulse: got %0b, expected %0b", sof_error, err_pending);
        end
      end
      if (sof_error) n_err++;
      err_pending = 0;
      if (in_valid && in_ready) begin
        emit = 0;
        if (!m_stream) begin
          if (in_sof) begin emit = 1; px = 0; py = 0; end
        end else begin
          emit = 1;
          if (in_sof) begin
            if (m_x != 0 || m_y != 0) err_pending = 1;
            px = 0; py = 0;
          end else begin
            px = m_x; py = m_y;
          end
        end
        if (emit) begin
          e.pix = (cur_exp >= 0) ? cur_exp : luma(int'(in_r), int'(in_g), int'(in_b));
          e.sof = (px == 0) && (py == 0);
          e.eol = (px == W - 1);
          e.eof = e.eol && (py == H - 1);
          q.push_back(e);
          if (e.eof) begin
            m_stream = 0; m_x = 0; m_y = 0;
          end else begin
            m_stream = 1;
            if (e.eol) begin m_x = 0; m_y = py + 1; end
            else begin m_x = px + 1; m_y = py; end
          end
        end
      end
    end else begin
      stall_prev  = 0;
      err_pending = 0;
      m_stream    = 0;
      m_x         = 0;
      m_y         = 0;
      q.delete();
    end
  end

  task automatic send(input int r, input int g, input int b, input bit sof, input int exp_pix);
    int n;
    in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
    in_sof = sof; cur_exp = exp_pix; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        checks++; errors++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0; cur_exp = -1;
  endtask

  task automatic send_rand(input bit sof);
    send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), sof, -1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue_empty", q.size(), 0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0, l0, f0, s0, e0, c0;
    tbl[0] = '{255, 255, 255, 255};
    tbl[1] = '{0,   0,   0,   0};
    tbl[2] = '{255, 0,   0,   77};
    tbl[3] = '{0,   255, 0,   149};
    tbl[4] = '{0,   0,   255, 29};
    tbl[5] = '{100, 50,  200, 82};
    tbl[6] = '{10,  20,  30,  18};
    tbl[7] = '{128, 128, 128, 128};
    tbl[8] = '{1,   1,   1,   1};
    tbl[9] = '{2,   0,   1,   1};

    // Reset values
    idle(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_sof",   out_sof,   0);
    check("rst_out_eol",   out_eol,   0);
    check("rst_out_eof",   out_eof,   0);
    check("rst_sof_error", sof_error, 0);
    check("rst_in_ready",  in_ready,  0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: two-cycle latency of the sof beat, then colour table
    send(255, 255, 255, 1'b1, 255);
    check("t1_valid_after_1", out_valid, 0);
    @(posedge clk);
    #1;
    check("t1_valid_after_2", out_valid, 1);
    check("t1_sof_after_2",   out_sof,   1);
    check("t1_pixel_after_2", out_pixel, 255);
    for (int i = 0; i < 10; i++) send(tbl[i].r, tbl[i].g, tbl[i].b, 1'b0, tbl[i].exp_pix);
    drain();

    // Test 2: beats before first sof are discarded
    do_reset();
    n0 = n_out; s0 = n_sof;
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    idle(6);
    check("t2_no_output_before_sof", n_out - n0, 0);
    send_rand(1'b1);
    drain();
    check("t2_one_output", n_out - n0, 1);
    check("t2_sof_seen",   n_sof - s0, 1);

    // Test 3: full frame at full rate
    do_reset();
    n0 = n_out; l0 = n_eol; f0 = n_eof;
    c0 = cyc;
    for (int k = 0; k < W * H; k++) send_rand(k == 0);
    check("t3_rate_cycles", cyc - c0, W * H);
    drain();
    check("t3_outputs", n_out - n0, W * H);
    check("t3_eol",     n_eol - l0, H);
    check("t3_eof",     n_eof - f0, 1);
    n0 = n_out;
    send_rand(1'b0);
    idle(6);
    check("t3_wait_sof_after_eof", n_out - n0, 0);

    // Test 4: random back-pressure and input gaps across frame boundaries
    do_reset();
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
      send_rand(i % 140 == 0);
    end
    ready_mode = 1;
    drain();

    // Test 5: out-of-place sof at (10,3) resynchronises
    do_reset();
    e0 = n_err; l0 = n_eol;
    for (int k = 0; k < 3 * W + 10; k++) send_rand(k == 0);
    send_rand(1'b1);
    for (int k = 0; k < W; k++) send_rand(1'b0);
    drain();
    idle(2);
    check("t5_error_pulses", n_err - e0, 1);
    check("t5_eol_count",    n_eol - l0, 4);

    // Test 6: reset with both stages full and downstream stalled
    do_reset();
    ready_mode = 0;
    idle(2);
    send(255, 255, 255, 1'b1, 255);
    send(255, 255, 255, 1'b0, 255);
    idle(2);
    check("t6_full_valid", out_valid, 1);
    check("t6_full_ready", in_ready,  0);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_pixel", out_pixel, 0);
    check("t6_rst_sof",   out_sof,   0);
    idle(2);
    @(negedge clk);
    reset = 1'b1;
    ready_mode = 1;
    @(posedge clk);
    #1;
    n0 = n_out;
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    idle(6);
    check("t6_nothing_before_sof", n_out - n0, 0);
    send_rand(1'b1);
    drain();
    check("t6_sof_after_reset", n_out - n0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
